cache_controller: RTL and testbench
===================================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 The module SHALL have parameter INDEX_BITS, default 6, giving 64 sets.
REQ-002 The module SHALL have parameter TAG_BITS, default 10, covering address[18:9].
REQ-003 The module SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port clk, input, 1: rising-edge clock for all state.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port rd_en, input, 1: pipeline load request; held until accepted.
REQ-007 Port wr_en, input, 1: pipeline store request; held until accepted.
REQ-008 Port address, input, 32: byte address (word-aligned).
REQ-009 Port wdata, input, 32: store data.
REQ-010 Port rdata, output, 32: load data, valid when ready=1 and the request is a load.
REQ-011 Port ready, output, 1: 0 = pipeline freeze; 1 = request completed or no request.
REQ-012 Port sram_rd_en / sram_wr_en, output, 1 each: requests to the SRAM controller.
REQ-013 Port sram_address, output, 32: address to the SRAM controller.
REQ-014 Port sram_wdata, output, 32: store data to the SRAM controller.
REQ-015 Port sram_rdata, input, 64: 64-bit line from the SRAM controller.
REQ-016 Port sram_ready, input, 1: SRAM controller idle/complete indication.

Function
REQ-017 Organisation SHALL be 2-way set-associative, 2^INDEX_BITS sets, 64-bit lines (2 words); per way: valid, tag, 64-bit data; per set: 1 LRU bit.
REQ-018 Address split SHALL be: word select = address[2], index = address[8:3], tag = address[18:9].
REQ-019 States SHALL be IDLE, RD_MISS, WR, DONE.
REQ-020 Read priority: rd_en=1 and wr_en=1 SHALL be treated as a read.
REQ-021 IDLE, read hit: ready=1, rdata = selected word of the hit way, combinationally in the same cycle; LRU[set] <= other way; stay IDLE.
REQ-022 IDLE, read miss: ready=0; next state RD_MISS.
REQ-023 IDLE, write: ready=0; a hitting way's valid bit SHALL be cleared; next state WR (write-through, no-write-allocate).
REQ-024 IDLE, no request: ready=1; no state change.
REQ-025 RD_MISS: sram_rd_en=1 and sram_address={address[31:3],3'b000}.
REQ-026 RD_MISS completion: on the first edge with sram_ready=1, the line SHALL be written into the victim way (valid=1, tag set), LRU[set] <= other way, the selected word latched for rdata, and the state SHALL go to DONE.
REQ-027 Victim selection: invalid way0, else invalid way1, else way LRU[set].
REQ-028 WR: sram_wr_en=1, sram_address=address, sram_wdata=wdata; on the first edge with sram_ready=1 the state SHALL go to DONE.
REQ-029 DONE: ready=1 for exactly one cycle; rdata = latched word (loads); sram_*_en=0; requests ignored; next state IDLE.
REQ-030 sram_rd_en and sram_wr_en SHALL be 0 in IDLE and DONE, and never both 1.
REQ-031 Pipeline inputs SHALL be held stable by the requester while ready=0; behaviour otherwise is undefined.
REQ-032 Miss latency SHALL be SRAM service cycles + 2 (the IDLE cycle plus the DONE cycle).

Reset
REQ-033 When rst=1 at an edge: state <= IDLE, all valid bits <= 0, all LRU bits <= 0, latched rdata <= 0.
REQ-034 Reset SHALL abort any RD_MISS/WR mid-operation; no partial line is written.
REQ-035 After reset: ready=1, sram_rd_en=0, sram_wr_en=0, rdata=0 with no request.

Verification
REQ-036 Cold read 0x100: RD_MISS with sram_address=0x100 until sram_ready; DONE rdata = sram_rdata[31:0]; then read 0x104 hits with ready=1 in the same cycle, returning [63:32].
REQ-037 Reads 0x100, 0x300, 0x500 (same set, distinct tags): the third fill evicts the 0x100 line; re-reading 0x300 hits and re-reading 0x100 misses.
REQ-038 Write 0x100 after it is cached: valid is cleared, sram_wr_en=1 with sram_wdata=wdata until sram_ready, DONE one cycle; next read 0x100 misses.
REQ-039 rd_en=1 and wr_en=1 to an uncached address: sram_rd_en=1, sram_wr_en stays 0.
REQ-040 rst=1 during RD_MISS: next cycle IDLE, ready=1, sram_rd_en=0; a read of the same address then misses.
REQ-041 sram_ready held 0 for 6 cycles during a miss: ready stays 0 and sram_rd_en stays 1 for all 6 cycles.

Source files
------------

// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate data cache
// sitting between the pipeline and a 64-bit-line SRAM controller.
module cache_controller #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);

    localparam int SETS    = 1 << INDEX_BITS;
    localparam int TAG_LSB = INDEX_BITS + 3;

    typedef enum logic [1:0] {
        IDLE,
        RD_MISS,
        WR,
        DONE
    } state_t;

    state_t                r_state;
    logic [SETS-1:0]       r_valid0;
    logic [SETS-1:0]       r_valid1;
    logic [SETS-1:0]       r_lru;
    logic [TAG_BITS-1:0]   r_tag0 [SETS];
    logic [TAG_BITS-1:0]   r_tag1 [SETS];
    logic [63:0]           r_data0 [SETS];
    logic [63:0]           r_data1 [SETS];
    logic [31:0]           r_rdata;

    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_word;
    logic                  w_hit0;
    logic                  w_hit1;
    logic                  w_hit;
    logic [63:0]           w_hit_line;
    logic [31:0]           w_hit_word;
    logic [31:0]           w_fill_word;
    logic                  w_victim;

    assign w_index = address[TAG_LSB-1:3];
    assign w_tag   = address[TAG_LSB +: TAG_BITS];
    assign w_word  = address[2];

    assign w_hit0 = r_valid0[w_index] && (r_tag0[w_index] == w_tag);
    assign w_hit1 = r_valid1[w_index] && (r_tag1[w_index] == w_tag);
    assign w_hit  = w_hit0 || w_hit1;

    assign w_hit_line  = w_hit0 ? r_data0[w_index] : r_data1[w_index];
    assign w_hit_word  = w_word ? w_hit_line[63:32] : w_hit_line[31:0];
    assign w_fill_word = w_word ? sram_rdata[63:32] : sram_rdata[31:0];

    // Fill an empty way first; only evict by LRU when both ways are live.
    always_comb begin
        w_victim = r_lru[w_index];
        if (!r_valid0[w_index]) begin
            w_victim = 1'b0;
        end else if (!r_valid1[w_index]) begin
            w_victim = 1'b1;
        end
    end

    always_comb begin
        ready        = 1'b0;
        rdata        = r_rdata;
        sram_rd_en   = 1'b0;
        sram_wr_en   = 1'b0;
        sram_address = 32'h0;
        sram_wdata   = 32'h0;
        unique case (r_state)
            IDLE: begin
                if (rd_en) begin
                    ready = w_hit;
                    if (w_hit) begin
                        rdata = w_hit_word;
                    end
                end else if (!wr_en) begin
                    ready = 1'b1;
                end
            end
            RD_MISS: begin
                sram_rd_en   = 1'b1;
                sram_address = {address[31:3], 3'b000};
            end
            WR: begin
                sram_wr_en   = 1'b1;
                sram_address = address;
                sram_wdata   = wdata;
            end
            DONE: begin
                ready = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_valid0 <= '0;
            r_valid1 <= '0;
            r_lru    <= '0;
            r_rdata  <= 32'h0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (rd_en) begin
                        if (w_hit) begin
                            r_lru[w_index] <= w_hit0;
                        end else begin
                            r_state <= RD_MISS;
                        end
                    end else if (wr_en) begin
                        // Write-through without allocate: drop any stale copy.
                        if (w_hit0) begin
                            r_valid0[w_index] <= 1'b0;
                        end
                        if (w_hit1) begin
                            r_valid1[w_index] <= 1'b0;
                        end
                        r_state <= WR;
                    end
                end
                RD_MISS: begin
                    if (sram_ready) begin
                        if (!w_victim) begin
                            r_valid0[w_index] <= 1'b1;
                            r_tag0[w_index]   <= w_tag;
                            r_data0[w_index]  <= sram_rdata;
                        end else begin
                            r_valid1[w_index] <= 1'b1;
                            r_tag1[w_index]   <= w_tag;
                            r_data1[w_index]  <= sram_rdata;
                        end
                        r_lru[w_index] <= ~w_victim;
                        r_rdata        <= w_fill_word;
                        r_state        <= DONE;
                    end
                end
                WR: begin
                    if (sram_ready) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural SRAM responder
// and a scoreboard queue of expected load data.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] address = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        ready;
    logic        sram_rd_en;
    logic        sram_wr_en;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic [63:0] sram_rdata;
    logic        sram_ready = 1'b0;

    int          n_chk = 0;
    int          n_fail = 0;
    int          svc_delay = 0;
    int          svc_cnt = 0;
    logic [31:0] exp_q[$];

    cache_controller dut (
        .clk          (clk),
        .rst          (rst),
        .rd_en        (rd_en),
        .wr_en        (wr_en),
        .address      (address),
        .wdata        (wdata),
        .rdata        (rdata),
        .ready        (ready),
        .sram_rd_en   (sram_rd_en),
        .sram_wr_en   (sram_wr_en),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] line_of(input logic [31:0] a);
        logic [31:0] al;
        al = a & ~32'h7;
        return {al ^ 32'hA5A5_0004, al ^ 32'h3C3C_0000};
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [63:0] l;
        l = line_of(a);
        return a[2] ? l[63:32] : l[31:0];
    endfunction

    assign sram_rdata = line_of(sram_address);

    // SRAM responder: raises sram_ready after svc_delay busy cycles.
    always @(posedge clk) begin
        if (rst || !(sram_rd_en || sram_wr_en)) begin
            svc_cnt    <= 0;
            sram_ready <= 1'b0;
        end else if (svc_cnt >= svc_delay) begin
            sram_ready <= 1'b1;
        end else begin
            svc_cnt    <= svc_cnt + 1;
            sram_ready <= 1'b0;
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic exp_hit,
                           input int d, input logic both);
        int n;
        svc_delay = d;
        @(negedge clk);
        address = a;
        rd_en   = 1'b1;
        wr_en   = both;
        wdata   = a ^ 32'h5555_0000;
        exp_q.push_back(word_of(a));
        #1;
        chk1("rd_hit_ready", ready, exp_hit);
        if (!ready) begin
            n = 0;
            while (n < 100) begin
                @(negedge clk);
                #1;
                n++;
                if (ready) break;
                chk1("rd_sram_rd_en", sram_rd_en, 1'b1);
                chk1("rd_sram_wr_en", sram_wr_en, 1'b0);
                chk32("rd_sram_addr", sram_address, a & ~32'h7);
            end
            chk1("rd_ready_timeout", ready, 1'b1);
            chkn("rd_miss_latency", n, d + 3);
        end
        chk32("rdata", rdata, exp_q.pop_front());
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] data,
                            input int d);
        int n;
        svc_delay = d;
        @(negedge clk);
        address = a;
        wdata   = data;
        wr_en   = 1'b1;
        #1;
        chk1("wr_ready_idle", ready, 1'b0);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            #1;
            n++;
            if (ready) break;
            chk1("wr_sram_wr_en", sram_wr_en, 1'b1);
            chk1("wr_sram_rd_en", sram_rd_en, 1'b0);
            chk32("wr_sram_addr", sram_address, a);
            chk32("wr_sram_wdata", sram_wdata, data);
        end
        chk1("wr_ready_timeout", ready, 1'b1);
        chkn("wr_latency", n, d + 3);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        #1;
        chk1("wr_sram_wr_en_after", sram_wr_en, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("rst_ready", ready, 1'b1);
        chk1("rst_sram_rd_en", sram_rd_en, 1'b0);
        chk1("rst_sram_wr_en", sram_wr_en, 1'b0);
        chk32("rst_rdata", rdata, 32'h0);

        // cold miss then both words of the line hit
        do_read(32'h0000_0100, 1'b0, 2, 1'b0);
        do_read(32'h0000_0104, 1'b1, 0, 1'b0);
        do_read(32'h0000_0100, 1'b1, 0, 1'b0);

        // three tags in one set: LRU eviction
        do_read(32'h0000_0300, 1'b0, 1, 1'b0);
        do_read(32'h0000_0500, 1'b0, 0, 1'b0);
        do_read(32'h0000_0304, 1'b1, 0, 1'b0);
        do_read(32'h0000_0100, 1'b0, 3, 1'b0);
        do_read(32'h0000_0300, 1'b1, 0, 1'b0);

        // write-through invalidates the cached copy
        do_write(32'h0000_0100, 32'hCAFE_F00D, 2);
        do_read(32'h0000_0100, 1'b0, 1, 1'b0);
        do_read(32'h0000_0300, 1'b1, 0, 1'b0);
        do_write(32'h0000_0704, 32'h1234_5678, 0);

        // simultaneous rd_en and wr_en is a read
        do_read(32'h0000_0904, 1'b0, 1, 1'b1);
        do_read(32'h0000_0900, 1'b1, 0, 1'b0);

        // long SRAM stall
        do_read(32'h0001_2348, 1'b0, 6, 1'b0);

        // reset in the middle of a miss
        svc_delay = 10;
        @(negedge clk);
        address = 32'h0000_0A00;
        rd_en   = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk1("pre_rst_sram_rd_en", sram_rd_en, 1'b1);
        chk1("pre_rst_ready", ready, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        rd_en = 1'b0;
        #1;
        chk1("abort_ready", ready, 1'b1);
        chk1("abort_sram_rd_en", sram_rd_en, 1'b0);
        chk1("abort_sram_wr_en", sram_wr_en, 1'b0);
        chk32("abort_rdata", rdata, 32'h0);
        do_read(32'h0000_0A00, 1'b0, 2, 1'b0);
        do_read(32'h0000_0300, 1'b0, 0, 1'b0);
        do_read(32'h0000_0A04, 1'b1, 0, 1'b0);

        chkn("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
